aclk_set_ctrl: RTL and testbench

//  User-facing setting sequencer for the alarm clock core. Turns six push-button

---
 rtl/aclk_set_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aclk_set_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_set_ctrl.sv
// aclk_set_ctrl: push-button setting sequencer for the alarm clock core.
// Edits time or alarm digit by digit and hands the result over with one-cycle load strobes.
module aclk_set_ctrl #(
  parameter int TIMEOUT_TICKS = 300,
  parameter int TMO_W         = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_time,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_al_tgl,
  input  logic       btn_stop,
  input  logic       Alarm,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic       editing,
  output logic [1:0] edit_digit
);

  typedef enum logic [2:0] {IDLE, E_H1, E_H0, E_M1, E_M0, COMMIT} state_t;

  state_t           state, state_d;
  logic             tgt, tgt_d;
  logic [TMO_W-1:0] tmo, tmo_d;
  logic [1:0]       e_h1, e_h1_d, sh_h1;
  logic [3:0]       e_h0, e_h0_d, e_m1, e_m1_d, e_m0, e_m0_d;
  logic [3:0]       sh_h0, sh_m1, sh_m0;
  logic [3:0]       h0_max;
  logic [5:0]       btn, btn_q, press;
  logic             edit_d;
  logic [1:0]       digit_d;

  // Bit order: 0 time, 1 alarm, 2 inc, 3 next, 4 al_tgl, 5 stop
  assign btn    = {btn_stop, btn_al_tgl, btn_next, btn_inc, btn_alarm, btn_time};
  assign press  = btn & ~btn_q;
  assign h0_max = (e_h1 == 2'd2) ? 4'd3 : 4'd9;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    tmo_d   = '0;
    e_h1_d  = e_h1;
    e_h0_d  = e_h0;
    e_m1_d  = e_m1;
    e_m0_d  = e_m0;
    edit_d  = 1'b0;
    digit_d = 2'd0;
    case (state)
      IDLE: begin
        if (press[0]) begin
          state_d = E_H1;
          tgt_d   = 1'b0;
          e_h1_d  = H_out1;
          e_h0_d  = H_out0;
          e_m1_d  = M_out1;
          e_m0_d  = M_out0;
        end else if (press[1]) begin
          state_d = E_H1;
          tgt_d   = 1'b1;
          e_h1_d  = sh_h1;
          e_h0_d  = sh_h0;
          e_m1_d  = sh_m1;
          e_m0_d  = sh_m0;
        end
      end
      E_H1, E_H0, E_M1, E_M0: begin
        tmo_d = (|press) ? '0 : tmo + TMO_W'(1);
        if (press[3]) begin
          case (state)
            E_H1:    state_d = E_H0;
            E_H0:    state_d = E_M1;
            E_M1:    state_d = E_M0;
            default: state_d = COMMIT;
          endcase
        end else begin
          if (press[2]) begin
            case (state)
              E_H1: begin
                e_h1_d = (e_h1 >= 2'd2) ? 2'd0 : e_h1 + 2'd1;
                // Keep the hour legal the moment the tens digit reaches 2
                if (e_h1_d == 2'd2 && e_h0 > 4'd3) e_h0_d = 4'd0;
              end
              E_H0:    e_h0_d = (e_h0 >= h0_max) ? 4'd0 : e_h0 + 4'd1;
              E_M1:    e_m1_d = (e_m1 >= 4'd5) ? 4'd0 : e_m1 + 4'd1;
              default: e_m0_d = (e_m0 >= 4'd9) ? 4'd0 : e_m0 + 4'd1;
            endcase
          end
          if (tmo_d == TMO_W'(TIMEOUT_TICKS)) begin
            state_d = IDLE;
            tmo_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      E_H1:    begin edit_d = 1'b1; digit_d = 2'd0; end
      E_H0:    begin edit_d = 1'b1; digit_d = 2'd1; end
      E_M1:    begin edit_d = 1'b1; digit_d = 2'd2; end
      E_M0:    begin edit_d = 1'b1; digit_d = 2'd3; end
      default: begin edit_d = 1'b0; digit_d = 2'd0; end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q      <= '0;
      tgt        <= 1'b0;
      tmo        <= '0;
      e_h1       <= '0;
      e_h0       <= '0;
      e_m1       <= '0;
      e_m0       <= '0;
      sh_h1      <= '0;
      sh_h0      <= '0;
      sh_m1      <= '0;
      sh_m0      <= '0;
      H_in1      <= '0;
      H_in0      <= '0;
      M_in1      <= '0;
      M_in0      <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_al    <= 1'b0;
      AL_ON      <= 1'b0;
      editing    <= 1'b0;
      edit_digit <= 2'd0;
    end else begin
      btn_q      <= btn;
      tgt        <= tgt_d;
      tmo        <= tmo_d;
      e_h1       <= e_h1_d;
      e_h0       <= e_h0_d;
      e_m1       <= e_m1_d;
      e_m0       <= e_m0_d;
      LD_time    <= (state_d == COMMIT) && !tgt_d;
      LD_alarm   <= (state_d == COMMIT) && tgt_d;
      STOP_al    <= press[5] && Alarm;
      editing    <= edit_d;
      edit_digit <= digit_d;
      if (state == IDLE && press[4]) AL_ON <= ~AL_ON;
      if (state_d == COMMIT) begin
        H_in1 <= e_h1;
        H_in0 <= e_h0;
        M_in1 <= e_m1;
        M_in0 <= e_m0;
        if (tgt_d) begin
          sh_h1 <= e_h1;
          sh_h0 <= e_h0;
          sh_m1 <= e_m1;
          sh_m0 <= e_m0;
        end
      end
    end
  end

endmodule

// File: tb/tb_aclk_set_ctrl.sv
// tb_aclk_set_ctrl: self-checking bench for the alarm clock setting sequencer.
// Table vectors, directed corner sequences and random stimulus against a digit-level model.
module tb_aclk_set_ctrl;

  localparam int TMO = 300;
  localparam logic [5:0] B_NONE  = 6'h00;
  localparam logic [5:0] B_TIME  = 6'h01;
  localparam logic [5:0] B_ALARM = 6'h02;
  localparam logic [5:0] B_INC   = 6'h04;
  localparam logic [5:0] B_NEXT  = 6'h08;
  localparam logic [5:0] B_TGL   = 6'h10;
  localparam logic [5:0] B_STOP  = 6'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_time, btn_alarm, btn_inc, btn_next, btn_al_tgl, btn_stop;
  logic       Alarm;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, editing;
  logic [1:0] edit_digit;

  always #5 clk = ~clk;

  aclk_set_ctrl #(.TIMEOUT_TICKS(TMO), .TMO_W(9)) dut (
    .clk(clk), .reset(reset),
    .btn_time(btn_time), .btn_alarm(btn_alarm), .btn_inc(btn_inc),
    .btn_next(btn_next), .btn_al_tgl(btn_al_tgl), .btn_stop(btn_stop),
    .Alarm(Alarm),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
    .AL_ON(AL_ON), .editing(editing), .edit_digit(edit_digit)
  );

  typedef struct {
    logic [5:0]  btn;
    logic        xp_edit;
    logic [1:0]  xp_dig;
    logic        xp_ld;
    logic [13:0] xp_hin;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: digits as plain integers, mode as flags
  logic [5:0] m_prev;
  bit m_edit, m_commit, m_tgt, m_alon, m_ld_t, m_ld_a, m_stop;
  int m_dig, m_idle;
  int d[4];
  int sh[4];
  int hin[4];

  function automatic int digitMax(input int idx, input int h1);
    case (idx)
      0:       return 2;
      1:       return (h1 == 2) ? 3 : 9;
      2:       return 5;
      default: return 9;
    endcase
  endfunction

  task automatic modelStep(input logic [5:0] b, input logic al, input logic rst);
    logic [5:0] p;
    if (rst) begin
      m_prev = '0; m_edit = 0; m_commit = 0; m_tgt = 0; m_alon = 0;
      m_ld_t = 0; m_ld_a = 0; m_stop = 0; m_dig = 0; m_idle = 0;
      d = '{0, 0, 0, 0}; sh = '{0, 0, 0, 0}; hin = '{0, 0, 0, 0};
    end else begin
      p = b & ~m_prev;
      m_prev = b;
      m_ld_t = 0;
      m_ld_a = 0;
      m_stop = p[5] && al;
      if (m_commit) begin
        m_commit = 0;
      end else if (!m_edit) begin
        if (p[4]) m_alon = !m_alon;
        if (p[0]) begin
          m_edit = 1; m_dig = 0; m_idle = 0; m_tgt = 0;
          d = '{int'(H_out1), int'(H_out0), int'(M_out1), int'(M_out0)};
        end else if (p[1]) begin
          m_edit = 1; m_dig = 0; m_idle = 0; m_tgt = 1;
          d = sh;
        end
      end else begin
        if (p != 0) m_idle = 0;
        else        m_idle++;
        if (p[3]) begin
          if (m_dig == 3) begin
            m_edit = 0; m_commit = 1; hin = d;
            if (m_tgt) begin m_ld_a = 1; sh = d; end
            else       m_ld_t = 1;
          end else begin
            m_dig++;
          end
        end else begin
          if (p[2]) begin
            d[m_dig] = (d[m_dig] >= digitMax(m_dig, d[0])) ? 0 : d[m_dig] + 1;
            if (m_dig == 0 && d[0] == 2 && d[1] > 3) d[1] = 0;
          end
          if (m_idle >= TMO) m_edit = 0;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [13:0] xh;
    xh = {2'(hin[0]), 4'(hin[1]), 4'(hin[2]), 4'(hin[3])};
    checkVal("editing", 16'(editing), 16'(m_edit));
    checkVal("edit_digit", 16'(edit_digit), m_edit ? 16'(m_dig) : 16'd0);
    checkVal("LD_time", 16'(LD_time), 16'(m_ld_t));
    checkVal("LD_alarm", 16'(LD_alarm), 16'(m_ld_a));
    checkVal("STOP_al", 16'(STOP_al), 16'(m_stop));
    checkVal("AL_ON", 16'(AL_ON), 16'(m_alon));
    checkVal("H_in/M_in", 16'({H_in1, H_in0, M_in1, M_in0}), 16'(xh));
  endtask

  task automatic applyStimulus(input logic [5:0] b, input logic rst);
    {btn_stop, btn_al_tgl, btn_next, btn_inc, btn_alarm, btn_time} = b;
    reset = rst;
    @(posedge clk);
    modelStep(b, Alarm, rst);
    #1;
    checkOutput();
  endtask

  task automatic pressBtn(input logic [5:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(b, 1'b0);
      applyStimulus(B_NONE, 1'b0);
    end
  endtask

  task automatic addPair(input logic [5:0] b, input int n, input logic [1:0] dig);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = '{b, 1'b1, dig, 1'b0, 14'h0};
      vecs.push_back(v);
      v.btn = B_NONE;
      vecs.push_back(v);
    end
  endtask

  function automatic logic [15:0] hinWord();
    return 16'({H_in1, H_in0, M_in1, M_in0});
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    reset = 1'b1; Alarm = 1'b0;
    H_out1 = 2'd0; H_out0 = 4'd0; M_out1 = 4'd0; M_out0 = 4'd0;
    {btn_stop, btn_al_tgl, btn_next, btn_inc, btn_alarm, btn_time} = B_NONE;

    applyStimulus(B_NONE, 1'b1);
    applyStimulus(B_NONE, 1'b1);
    checkVal("rst_editing", 16'(editing), 16'd0);
    checkVal("rst_al_on", 16'(AL_ON), 16'd0);
    checkVal("rst_hin", hinWord(), 16'd0);
    applyStimulus(B_NONE, 1'b0);

    // Test 1: edit 00:00 up to 23:45 and commit as time
    addPair(B_TIME, 1, 2'd0);
    addPair(B_INC, 2, 2'd0);
    addPair(B_NEXT, 1, 2'd1);
    addPair(B_INC, 3, 2'd1);
    addPair(B_NEXT, 1, 2'd2);
    addPair(B_INC, 4, 2'd2);
    addPair(B_NEXT, 1, 2'd3);
    addPair(B_INC, 5, 2'd3);
    v = '{B_NEXT, 1'b0, 2'd0, 1'b1, {2'd2, 4'd3, 4'd4, 4'd5}};
    vecs.push_back(v);
    v = '{B_NONE, 1'b0, 2'd0, 1'b0, {2'd2, 4'd3, 4'd4, 4'd5}};
    vecs.push_back(v);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].btn, 1'b0);
      checkVal("t1_editing", 16'(editing), 16'(vecs[i].xp_edit));
      checkVal("t1_digit", 16'(edit_digit), 16'(vecs[i].xp_dig));
      checkVal("t1_ld_time", 16'(LD_time), 16'(vecs[i].xp_ld));
      checkVal("t1_hin", hinWord(), 16'(vecs[i].xp_hin));
    end

    // Test 2: 19:27, H1 to 2 clamps H0, then H0 wraps at 3
    H_out1 = 2'd1; H_out0 = 4'd9; M_out1 = 4'd2; M_out0 = 4'd7;
    pressBtn(B_TIME, 1);
    pressBtn(B_INC, 1);
    pressBtn(B_NEXT, 1);
    pressBtn(B_INC, 4);
    pressBtn(B_NEXT, 2);
    applyStimulus(B_NEXT, 1'b0);
    checkVal("t2_ld_time", 16'(LD_time), 16'd1);
    checkVal("t2_hin", hinWord(), 16'({2'd2, 4'd0, 4'd2, 4'd7}));
    applyStimulus(B_NONE, 1'b0);
    checkVal("t2_ld_clear", 16'(LD_time), 16'd0);

    // Test 3: alarm 07:30, then reopen and confirm it seeds from the shadow
    pressBtn(B_ALARM, 1);
    pressBtn(B_NEXT, 1);
    pressBtn(B_INC, 7);
    pressBtn(B_NEXT, 1);
    pressBtn(B_INC, 3);
    pressBtn(B_NEXT, 1);
    applyStimulus(B_NEXT, 1'b0);
    checkVal("t3_ld_alarm", 16'(LD_alarm), 16'd1);
    checkVal("t3_ld_time", 16'(LD_time), 16'd0);
    checkVal("t3_hin", hinWord(), 16'({2'd0, 4'd7, 4'd3, 4'd0}));
    applyStimulus(B_NONE, 1'b0);
    pressBtn(B_ALARM, 1);
    pressBtn(B_NEXT, 3);
    pressBtn(B_INC, 1);
    applyStimulus(B_NEXT, 1'b0);
    checkVal("t3_reseed", hinWord(), 16'({2'd0, 4'd7, 4'd3, 4'd1}));
    applyStimulus(B_NONE, 1'b0);

    // Test 4: alarm enable toggle and stop strobe
    pressBtn(B_TGL, 1);
    checkVal("t4_al_on", 16'(AL_ON), 16'd1);
    pressBtn(B_TIME, 1);
    pressBtn(B_NEXT, 1);
    pressBtn(B_TGL, 1);
    checkVal("t4_tgl_ignored", 16'(AL_ON), 16'd1);
    checkVal("t4_digit", 16'(edit_digit), 16'd1);
    pressBtn(B_NEXT, 3);
    Alarm = 1'b1;
    applyStimulus(B_STOP, 1'b0);
    checkVal("t4_stop", 16'(STOP_al), 16'd1);
    applyStimulus(B_STOP, 1'b0);
    checkVal("t4_stop_once", 16'(STOP_al), 16'd0);
    applyStimulus(B_NONE, 1'b0);
    Alarm = 1'b0;
    applyStimulus(B_STOP, 1'b0);
    checkVal("t4_stop_noalarm", 16'(STOP_al), 16'd0);
    applyStimulus(B_NONE, 1'b0);

    // Test 5: idle timeout, restarted by a press one cycle before expiry
    pressBtn(B_TIME, 1);
    applyStimulus(B_INC, 1'b0);
    for (int i = 0; i < 298; i++) applyStimulus(B_NONE, 1'b0);
    applyStimulus(B_INC, 1'b0);
    checkVal("t5_restart", 16'(editing), 16'd1);
    for (int i = 0; i < 299; i++) applyStimulus(B_NONE, 1'b0);
    checkVal("t5_before_tmo", 16'(editing), 16'd1);
    applyStimulus(B_NONE, 1'b0);
    checkVal("t5_tmo_exit", 16'(editing), 16'd0);
    checkVal("t5_no_ld", 16'({LD_time, LD_alarm}), 16'd0);

    // Test 6: reset mid-edit, then inc+next in the same cycle
    pressBtn(B_TIME, 1);
    pressBtn(B_NEXT, 2);
    checkVal("t6_in_m1", 16'(edit_digit), 16'd2);
    applyStimulus(B_NONE, 1'b1);
    checkVal("t6_rst_editing", 16'(editing), 16'd0);
    checkVal("t6_rst_al_on", 16'(AL_ON), 16'd0);
    checkVal("t6_rst_hin", hinWord(), 16'd0);
    applyStimulus(B_NONE, 1'b0);
    pressBtn(B_ALARM, 1);
    pressBtn(B_NEXT, 3);
    pressBtn(B_INC, 1);
    applyStimulus(B_NEXT, 1'b0);
    checkVal("t6_shadow_cleared", hinWord(), 16'({2'd0, 4'd0, 4'd0, 4'd1}));
    applyStimulus(B_NONE, 1'b0);
    H_out1 = 2'd1; H_out0 = 4'd2; M_out1 = 4'd3; M_out0 = 4'd4;
    pressBtn(B_TIME, 1);
    pressBtn(B_INC | B_NEXT, 1);
    checkVal("t6_next_wins", 16'(edit_digit), 16'd1);
    pressBtn(B_NEXT, 2);
    applyStimulus(B_NEXT, 1'b0);
    checkVal("t6_inc_dropped", hinWord(), 16'({2'd1, 4'd2, 4'd3, 4'd4}));
    applyStimulus(B_NONE, 1'b0);

    // Random stimulus against the model, including out-of-range seed digits
    for (int i = 0; i < 800; i++) begin
      logic [5:0] b;
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 3) == 0);
      Alarm  = 1'($urandom_range(0, 1));
      H_out1 = 2'($urandom_range(0, 3));
      H_out0 = 4'($urandom_range(0, 15));
      M_out1 = 4'($urandom_range(0, 15));
      M_out0 = 4'($urandom_range(0, 15));
      applyStimulus(b, ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
